// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead subtractor.
// Holds the slice width, slice result type and operand-width legality check.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef struct packed {
    logic [SLICE_W-1:0] sum;
    logic               cout;
  } slice_res_t;

  // Operand width must split evenly into slices and give at least two stages.
  function automatic bit width_ok(input int w);
    return (w >= 2 * SLICE_W) && ((w % SLICE_W) == 0);
  endfunction

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead slice: s = x + y + ci, co = carry out.
// Zero latency; no handshake, so it never stalls.
module cla_slice4
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W:0]   w_c;
  slice_res_t         w_res;

  assign w_g = x & y;
  assign w_p = x ^ y;

  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  assign w_res = '{sum: w_p ^ w_c[SLICE_W-1:0], cout: w_c[SLICE_W]};
  assign s     = w_res.sum;
  assign co    = w_res.cout;

endmodule

// File: rtl/cla_sub_pipe.sv
// Pipelined subtractor diff = a - b - bin, one 4-bit lookahead slice per stage.
// Latency WIDTH/4 cycles; global stall: every stage holds while out_valid & ~out_ready.
// Optional signed overflow output enabled by defining CLA_SUB_OVF_EN.
module cla_sub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CLA_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / SLICE_W;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("cla_sub_pipe: WIDTH must be a multiple of 4 and >= 8");
  end

  logic [STAGES-1:0]              r_vld;
  logic [WIDTH-1:0]               r_d  [STAGES];
  logic [WIDTH-1:0]               r_a  [STAGES-1];
  logic [WIDTH-1:0]               r_nb [STAGES-1];
  logic [STAGES-2:0]              r_c;
  logic                           r_bout;

  logic                           w_en;
  logic [STAGES-1:0][SLICE_W-1:0] w_x;
  logic [STAGES-1:0][SLICE_W-1:0] w_y;
  logic [STAGES-1:0][SLICE_W-1:0] w_s;
  logic [STAGES-1:0]              w_ci;
  logic [STAGES-1:0]              w_co;
  logic [STAGES-1:0][WIDTH-1:0]   w_dn;

  assign w_en     = out_ready | ~r_vld[STAGES-1];
  assign in_ready = w_en;

  // Subtraction as a + ~b + ~bin; each stage consumes one nibble of the piped operands.
  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    if (k == 0) begin : g_first
      assign w_x[k]  = a[SLICE_W-1:0];
      assign w_y[k]  = ~b[SLICE_W-1:0];
      assign w_ci[k] = ~bin;
      assign w_dn[k] = WIDTH'(w_s[k]);
    end else begin : g_rest
      assign w_x[k]  = r_a[k-1][SLICE_W*k +: SLICE_W];
      assign w_y[k]  = r_nb[k-1][SLICE_W*k +: SLICE_W];
      assign w_ci[k] = r_c[k-1];
      assign w_dn[k] = r_d[k-1] | (WIDTH'(w_s[k]) << (SLICE_W * k));
    end

    cla_slice4 u_slice (
      .x  (w_x[k]),
      .y  (w_y[k]),
      .ci (w_ci[k]),
      .s  (w_s[k]),
      .co (w_co[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_c    <= '0;
      r_bout <= 1'b0;
      for (int k = 0; k < STAGES; k++) r_d[k] <= '0;
      for (int k = 0; k < STAGES - 1; k++) begin
        r_a[k]  <= '0;
        r_nb[k] <= '0;
      end
    end else if (w_en) begin
      r_vld   <= {r_vld[STAGES-2:0], in_valid};
      r_a[0]  <= a;
      r_nb[0] <= ~b;
      for (int k = 1; k < STAGES - 1; k++) begin
        r_a[k]  <= r_a[k-1];
        r_nb[k] <= r_nb[k-1];
      end
      for (int k = 0; k < STAGES; k++) r_d[k] <= w_dn[k];
      r_c    <= w_co[STAGES-2:0];
      r_bout <= ~w_co[STAGES-1];
    end
  end

`ifdef CLA_SUB_OVF_EN
  logic r_ovf;

  // Sign bits come from the operands piped into the last stage; b's sign is ~(~b).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_en) begin
      r_ovf <= (r_a[STAGES-2][WIDTH-1] ^ ~r_nb[STAGES-2][WIDTH-1])
             & (w_s[STAGES-1][SLICE_W-1] ^ r_a[STAGES-2][WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`endif

  assign out_valid = r_vld[STAGES-1];
  assign diff      = r_d[STAGES-1];
  assign bout      = r_bout;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Directed bench for cla_sub_pipe at WIDTH=16: latency, borrow, throughput, stall, reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cla_sub_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
`ifdef CLA_SUB_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cla_sub_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef CLA_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Reference: {bout, diff} from an unsigned (W+1)-bit subtraction.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL reset_diff: got %h want 0000", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b want 0", bout); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++; if (diff !== 16'h1000) begin errors++; $display("FAIL basic_diff: got %h want 1000", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL basic_bout: got %b want 0", bout); end
  endtask

  task automatic test_borrow();
    logic [W-1:0] va [3] = '{16'h0000, 16'h0000, 16'h5A5A};
    logic [W-1:0] vb [3] = '{16'h0001, 16'h0000, 16'h5A5A};
    logic         vi [3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] ed [3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
    logic         eb [3] = '{1'b1, 1'b1, 1'b0};
    int cyc;
    idle(5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; bin = vi[i]; in_valid = 1'b1; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL borrow_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (diff !== ed[i]) begin errors++; $display("FAIL borrow_diff[%0d]: got %h want %h", i, diff, ed[i]); end
      checks++; if (bout !== eb[i]) begin errors++; $display("FAIL borrow_bout[%0d]: got %b want %b", i, bout, eb[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0]   q [$];
    logic [W:0]   exp;
    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic         vi [8];
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1;
    for (int i = 0; i < 8; i++) begin
      va[i] = W'($urandom); vb[i] = W'($urandom); vi[i] = 1'($urandom);
    end
    idle(5);
    while (got < 8 && cyc < 100) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (sent < 8) begin
        a = va[sent]; b = vb[sent]; bin = vi[sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid === 1'b1) begin
        exp = (q.size() > 0) ? q.pop_front() : 'x;
        checks++; if ({bout, diff} !== exp) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", got, {bout, diff}, exp); end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_sub(va[sent], vb[sent], vi[sent]));
        sent++;
      end
      cyc++;
    end
    checks++; if (got !== 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got); end
    checks++; if (last - first !== 7) begin errors++; $display("FAIL b2b_consecutive: got span %0d want 7", last - first); end
  endtask

  task automatic test_backpressure();
    logic [W:0]   q [$];
    logic [W:0]   exp;
    logic [W:0]   held;
    logic [W-1:0] va [5] = '{16'h1000, 16'h0003, 16'hFFFF, 16'h8000, 16'h00F0};
    logic [W-1:0] vb [5] = '{16'h0001, 16'h0004, 16'h0001, 16'h8000, 16'h000F};
    logic         vi [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int sent = 0, got = 0, cyc = 0;
    idle(5);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (sent < 5) begin
        a = va[sent]; b = vb[sent]; bin = vi[sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 4) held = {bout, diff};
      if (in_valid && in_ready) begin
        q.push_back(ref_sub(va[sent], vb[sent], vi[sent]));
        sent++;
      end
    end
    checks++; if (sent !== 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", sent); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    checks++; if ({bout, diff} !== held) begin errors++; $display("FAIL bp_frozen: got %h want %h", {bout, diff}, held); end
    checks++; if (held !== ref_sub(va[0], vb[0], vi[0])) begin errors++; $display("FAIL bp_head: got %h want %h", held, ref_sub(va[0], vb[0], vi[0])); end
    while (got < 5 && cyc < 50) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (sent < 5) begin
        a = va[sent]; b = vb[sent]; bin = vi[sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid === 1'b1) begin
        exp = (q.size() > 0) ? q.pop_front() : 'x;
        checks++; if ({bout, diff} !== exp) begin errors++; $display("FAIL bp_drain[%0d]: got %h want %h", got, {bout, diff}, exp); end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_sub(va[sent], vb[sent], vi[sent]));
        sent++;
      end
      cyc++;
    end
    checks++; if (got !== 5) begin errors++; $display("FAIL bp_drain_count: got %0d want 5", got); end
  endtask

  task automatic test_reset_midop();
    int stale = 0;
    idle(5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 16'h0000; b = 16'h0005 + W'(i); bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++; if ({out_valid, bout, diff} !== {1'b1, 1'b1, 16'hFFFB}) begin errors++; $display("FAIL midop_before: got %b %b %h want 1 1 fffb", out_valid, bout, diff); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midop_valid: got %b want 0", out_valid); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL midop_diff: got %h want 0000", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL midop_bout: got %b want 0", bout); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL midop_stale: got %0d valid cycles want 0", stale); end
  endtask

`ifdef CLA_SUB_OVF_EN
  task automatic test_overflow();
    logic [W-1:0] va [3] = '{16'h8000, 16'h7FFF, 16'h0005};
    logic [W-1:0] vb [3] = '{16'h0001, 16'hFFFF, 16'h0003};
    logic [W-1:0] ed [3] = '{16'h7FFF, 16'h8000, 16'h0002};
    logic         eo [3] = '{1'b1, 1'b1, 1'b0};
    int cyc;
    idle(5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (diff !== ed[i]) begin errors++; $display("FAIL ovf_diff[%0d]: got %h want %h", i, diff, ed[i]); end
      checks++; if (ovf !== eo[i]) begin errors++; $display("FAIL ovf_flag[%0d]: got %b want %b", i, ovf, eo[i]); end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
`ifdef CLA_SUB_OVF_EN
    test_overflow();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
